// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an external PWM input in
// clk_i cycles and exposes the results on the 8-bit register bus.
// A four-state FSM counts from the first rising edge. On each later rising
// edge it publishes the high time and period together.
module pwm_capture #(
  parameter int CNT_W = 16
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic [7:0] b_addr_i,
  input  logic [7:0] b_data_i,
  output logic [7:0] b_data_o,
  input  logic [1:0] b_event_i,
  input  logic       pwm_i,
  output logic       irq_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1_q, sync2_q, prev_q;
  logic             rise, fall;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_cap_q, high_cap_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             en_q, irq_en_q;
  logic [2:0]       stat_q, stat_d, stat_set;
  logic [7:0]       shadow_high_q, shadow_high_d;
  logic [7:0]       shadow_per_q, shadow_per_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             irq_q;
  logic             rd_ev, wr_ev, ctrl_wr, stat_wr;
  logic [15:0]      high_ext, per_ext;
  logic             unused_data_bits;

  assign rd_ev   = (b_event_i == 2'b01);
  assign wr_ev   = (b_event_i == 2'b11);
  assign ctrl_wr = wr_ev && (b_addr_i == 8'h00);
  assign stat_wr = wr_ev && (b_addr_i == 8'h01);

  // Only the low three write-data bits reach any register.
  assign unused_data_bits = ^b_data_i[7:3];

  // Results are zero-extended to the 16-bit register view.
  assign high_ext = 16'(high_q);
  assign per_ext  = 16'(per_q);

  // Two-flop synchronizer followed by the edge-detect history flop.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= pwm_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  // Measurement FSM: counts edge to edge and publishes on every rise after the first.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_cap_d = high_cap_q;
    high_d     = high_q;
    per_d      = per_q;
    stat_set   = 3'b000;
    if (!en_q) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          state_d = ST_ARM;
        end
        ST_ARM: begin
          if (rise) begin
            cnt_d   = CNT_ONE;
            state_d = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (cnt_q == CNT_MAX) begin
            stat_set[1] = 1'b1;
            cnt_d       = '0;
            state_d     = ST_ARM;
          end else if (fall) begin
            // Hold the high time until the period closes so both publish together.
            high_cap_d = cnt_q;
            cnt_d      = cnt_q + CNT_ONE;
            state_d    = ST_LOW;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_LOW: begin
          if (cnt_q == CNT_MAX) begin
            stat_set[1] = 1'b1;
            cnt_d       = '0;
            state_d     = ST_ARM;
          end else if (rise) begin
            high_d      = high_cap_q;
            per_d       = cnt_q;
            stat_set[0] = 1'b1;
            stat_set[2] = stat_q[0];
            cnt_d       = CNT_ONE;
            state_d     = ST_HIGH;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sticky status bits: write-1 clears, and a same-cycle set takes precedence.
  for (genvar gi = 0; gi < 3; gi++) begin : g_status
    assign stat_d[gi] = stat_set[gi] | (stat_q[gi] & ~(stat_wr & b_data_i[gi]));
  end

  // Read mux; a LO read snapshots the matching high byte for the HI read.
  always_comb begin
    rdata_d       = rdata_q;
    shadow_high_d = shadow_high_q;
    shadow_per_d  = shadow_per_q;
    if (rd_ev) begin
      case (b_addr_i)
        8'h00: rdata_d = {6'b0, irq_en_q, en_q};
        8'h01: rdata_d = {4'b0, sync2_q, stat_q};
        8'h02: begin
          rdata_d       = high_ext[7:0];
          shadow_high_d = high_ext[15:8];
        end
        8'h03: rdata_d = shadow_high_q;
        8'h04: begin
          rdata_d      = per_ext[7:0];
          shadow_per_d = per_ext[15:8];
        end
        8'h05: rdata_d = shadow_per_q;
        default: rdata_d = 8'h00;
      endcase
    end
  end

  // State, results, control, status and bus registers.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      high_cap_q    <= '0;
      high_q        <= '0;
      per_q         <= '0;
      en_q          <= 1'b0;
      irq_en_q      <= 1'b0;
      stat_q        <= 3'b000;
      shadow_high_q <= 8'h00;
      shadow_per_q  <= 8'h00;
      rdata_q       <= 8'h00;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      high_cap_q    <= high_cap_d;
      high_q        <= high_d;
      per_q         <= per_d;
      stat_q        <= stat_d;
      shadow_high_q <= shadow_high_d;
      shadow_per_q  <= shadow_per_d;
      rdata_q       <= rdata_d;
      irq_q         <= irq_en_q & (stat_q[0] | stat_q[1]);
      if (ctrl_wr) begin
        en_q     <= b_data_i[0];
        irq_en_q <= b_data_i[1];
      end
    end
  end

  assign b_data_o = rdata_q;
  assign irq_o    = irq_q;

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Measures an incoming PWM waveform: high time and period, in clk_i cycles. It is the receive-side counterpart of the pwm generator. It sits on the same 8-bit register bus (b_addr_i / b_data_i / b_data_o / b_event_i). It is used to loop back and check generator output, or to decode external PWM inputs.

Parameters:
CNT_W, 16, counter and result width. Legal range 9..16. Upper result bytes are zero-extended beyond CNT_W.

Ports:
clk_i  in  1  system clock, all logic on rising edge
nrst_i  in  1  reset; synchronous, active-low
b_addr_i  in  8  register address
b_data_i  in  8  write data
b_data_o  out  8  read data, registered
b_event_i  in  2  bus event: 2'b00 idle, 2'b01 read, 2'b11 write, 2'b10 reserved (ignored)
pwm_i  in  1  asynchronous PWM input
irq_o  out  1  interrupt, registered, level

Behaviour:
- Reset (nrst_i=0 at a clk_i edge):
  - all registers 0; FSM=IDLE
  - b_data_o=0, irq_o=0
  - synchronizer flops 0
- Input path: 2-flop synchronizer, then 1 edge-detect flop.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Fixed 3-cycle input latency. Measurements are edge-to-edge, so the latency does not bias them.
- Register map:
  - 0x00 CTRL (rw): bit0 EN, bit1 IRQ_EN, others read 0.
  - 0x01 STATUS (r, write-1-to-clear bits 0..2):
    - bit0 VALID
    - bit1 OVF
    - bit2 MISSED
    - bit3 LEVEL (synced pwm_i, read-only)
  - 0x02 HIGH_LO, 0x03 HIGH_HI, 0x04 PER_LO, 0x05 PER_HI (all r).
  - Other addresses read 0x00. Writes to read-only or unmapped addresses are ignored.
- Bus timing:
  - Write event at cycle n: register updated at the end of cycle n.
  - Read event at cycle n: b_data_o valid from cycle n+1 and held until the next read.
- Tear-free 16-bit reads:
  - Reading HIGH_LO copies the current HIGH[15:8] into a shadow; HIGH_HI returns the shadow.
  - PER_LO / PER_HI work the same way.
  - Software reads LO first.
- FSM:
  - IDLE: cnt=0. EN=1 -> ARM.
  - ARM: wait for rise. On rise: cnt<=1, -> HIGH.
  - HIGH: cnt increments each cycle. On fall: HIGH_REG<=cnt, -> LOW.
  - LOW: cnt increments. On rise: PER_REG<=cnt, publish, cnt<=1, -> HIGH.
  - Result: HIGH = t_fall - t_rise, PERIOD = t_rise2 - t_rise1, in cycles.
- Publish:
  - HIGH_REG and PER_REG become visible on the same cycle.
  - VALID<=1. If VALID was already 1, MISSED<=1.
  - Only the first period after arming is ever lost; every later period is published.
- Saturation:
  - If cnt reaches 2^CNT_W-1 in HIGH or LOW: OVF<=1, -> ARM, no publish.
  - This covers 0% and 100% duty and a missing signal. Published values are retained.
- EN cleared in any state: -> IDLE on the next cycle. cnt cleared; published values and STATUS retained.
- Simultaneous events:
  - Set and write-1-clear on the same STATUS bit in the same cycle: set wins.
  - Rise and fall cannot coincide (single-bit edge detect).
- irq_o <= IRQ_EN & (VALID | OVF), one cycle after the underlying condition.
- Reset mid-measurement: immediate return to reset values. There is no partial publish.

Test Plan:
- Reset then idle:
  - read 0x00..0x05 -> all 0x00, irq_o=0
  - read 0x06 -> 0x00
- Basic measurement:
  - Write 0x00<=0x03; drive pwm_i high 30 / low 70 cycles, repeated.
  - After the second rise: HIGH=30 (0x02=0x1E, 0x03=0x00), PERIOD=100 (0x04=0x64, 0x05=0x00).
  - VALID=1; irq_o=1.
- Wide values:
  - High 300, period 1000.
  - Read 0x02 -> 0x2C, 0x03 -> 0x01; read 0x04 -> 0xE8, 0x05 -> 0x03.
  - Change the waveform between the LO and HI reads: HI still matches the snapshot.
- Flags:
  - Leave VALID set across two periods -> MISSED=1.
  - Write 0x01<=0x07 -> STATUS bits 0..2 read 0, irq_o drops one cycle later.
  - Clear on the same cycle as a publish -> VALID stays 1.
- Saturation: hold pwm_i=1 for 65535+ cycles with EN=1 -> OVF=1, prior HIGH/PER unchanged, FSM re-arms, next full period measures correctly.
- Abort paths:
  - Clear EN mid-HIGH, then re-enable: the first period after re-enable is not published, the second is correct.
  - Assert nrst_i=0 mid-LOW -> all reads 0x00.
